// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer (registered in_ready), synchronous flush to an all-zero bubble, and a stall counter.
module pipe_stage_reg #(
   parameter int WIDTH = 32,
   parameter int SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             r_main_v;
   logic [WIDTH-1:0] r_main_d;
   logic             r_skid_v;
   logic [WIDTH-1:0] r_skid_d;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_in_xfer;
   logic             w_out_xfer;

   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = r_main_v && out_ready;

   generate
      if (SKID != 0) begin : g_skid
         // in_ready depends only on the skid register, so it never has a comb path from out_ready
         assign in_ready = !r_skid_v;

         always_ff @(posedge CLK) begin
            if (RST || flush) begin
               r_main_v <= 1'b0;
               r_main_d <= '0;
               r_skid_v <= 1'b0;
               r_skid_d <= '0;
            end else if (!r_main_v) begin
               if (w_in_xfer) begin
                  r_main_v <= 1'b1;
                  r_main_d <= in_data;
               end
            end else if (!r_skid_v) begin
               if (w_in_xfer && w_out_xfer) begin
                  r_main_d <= in_data;
               end else if (w_in_xfer) begin
                  r_skid_v <= 1'b1;
                  r_skid_d <= in_data;
               end else if (w_out_xfer) begin
                  r_main_v <= 1'b0;
                  r_main_d <= '0;
               end
            end else if (w_out_xfer) begin
               r_main_d <= r_skid_d;
               r_skid_v <= 1'b0;
               r_skid_d <= '0;
            end
         end
      end else begin : g_noskid
         assign in_ready = !r_main_v || out_ready;

         always_ff @(posedge CLK) begin
            if (RST || flush) begin
               r_main_v <= 1'b0;
               r_main_d <= '0;
            end else if (w_in_xfer) begin
               r_main_v <= 1'b1;
               r_main_d <= in_data;
            end else if (w_out_xfer) begin
               r_main_v <= 1'b0;
               r_main_d <= '0;
            end
         end

         always_comb begin
            r_skid_v = 1'b0;
            r_skid_d = '0;
         end
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_stall_cnt <= '0;
      end else if (r_main_v && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign out_valid = r_main_v;
   assign out_data  = r_main_d;
   assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};
   assign stall_cnt = r_stall_cnt;

endmodule
